// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: valid/ready command to single APB3 transfer master with wait-state timeout
module apb_master_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              cpu_psel,
  output logic              cpu_penable,
  output logic              cpu_pwrite,
  output logic [ADDR_W-1:0] cpu_paddr,
  output logic [DATA_W-1:0] cpu_pwdata,
  input  logic [DATA_W-1:0] cpu_prdata,
  input  logic              cpu_pready,
  input  logic              cpu_pslverr
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q, state_d;
  logic ready_q, ready_d, psel_q, psel_d, pen_q, pen_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic rvalid_q, rvalid_d, err_q, err_d, to_q, to_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic abort;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  // the counter value after this edge's low-pready cycle decides the abort, so pready still wins
  assign abort = (TIMEOUT != 0) && (cnt_inc == TO);
  always_comb begin
    state_d  = state_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    to_d     = to_q;
    case (state_q)
      IDLE: if (cmd_valid && ready_q) begin
        state_d  = SETUP;
        paddr_d  = cmd_addr;
        pwrite_d = cmd_write;
        pwdata_d = cmd_write ? cmd_wdata : '0;
        psel_d   = 1'b1;
        pen_d    = 1'b0;
        cnt_d    = '0;
      end
      SETUP: begin
        state_d = ACCESS;
        pen_d   = 1'b1;
      end
      ACCESS: begin
        cnt_d = cnt_inc;
        if (cpu_pready || abort) begin
          state_d  = IDLE;
          psel_d   = 1'b0;
          pen_d    = 1'b0;
          pwrite_d = 1'b0;
          pwdata_d = '0;
          rvalid_d = 1'b1;
          err_d    = cpu_pready ? cpu_pslverr : 1'b1;
          to_d     = !cpu_pready;
          rdata_d  = (cpu_pready && !pwrite_q) ? cpu_prdata : '0;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end
  assign cmd_ready   = ready_q;
  assign rsp_valid   = rvalid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;
  assign cpu_psel    = psel_q;
  assign cpu_penable = pen_q;
  assign cpu_pwrite  = pwrite_q;
  assign cpu_paddr   = paddr_q;
  assign cpu_pwdata  = pwdata_q;
endmodule
